// File: rtl/snake_pkg.sv
// Shared encodings for the snake motion engine: game states, direction codes,
// the grid cell type and the reverse-direction helper.
package snake_pkg;

    localparam int COORD_W = 5;

    typedef enum logic [1:0] {
        ST_DIE   = 2'b00,
        ST_PLAY  = 2'b01,
        ST_START = 2'b10,
        ST_WIN   = 2'b11
    } game_state_e;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_e;

    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
    } cell_t;

    function automatic dir_e reverse_dir(input dir_e d);
        dir_e r;
        case (d)
            DIR_UP:    r = DIR_DOWN;
            DIR_DOWN:  r = DIR_UP;
            DIR_LEFT:  r = DIR_RIGHT;
            default:   r = DIR_LEFT;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/snake_motion_engine_tick_gen.sv
// Free-running step counter: counts 0..TICK_CYCLES-1 while enabled, holds otherwise,
// and emits a one-cycle tick on the terminal count.
module tick_gen #(
    parameter int TICK_CYCLES = 5_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int CW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(TICK_CYCLES - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            if (cnt_q == CNT_MAX) cnt_d = '0;
            else                  cnt_d = cnt_q + 1'b1;
        end
    end

    assign tick = en && !clr && (cnt_q == CNT_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

endmodule

// File: rtl/snake_motion_engine.sv
// Snake movement, steering, growth and collision detection, plus a combinational
// body-occupancy lookup for the renderer.
module snake_motion_engine
    import snake_pkg::*;
#(
    parameter int GRID_W      = 32,
    parameter int GRID_H      = 24,
    parameter int MAX_LEN     = 16,
    parameter int START_LEN   = 3,
    parameter int TICK_CYCLES = 5_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] state,
    input  logic [3:0] BTN,
    input  logic [4:0] apple_x,
    input  logic [4:0] apple_y,
    output logic       apple_eaten,
    output logic       die,
    output logic       win,
    output logic [4:0] head_x,
    output logic [4:0] head_y,
    output logic [4:0] length,
    input  logic [4:0] query_x,
    input  logic [4:0] query_y,
    output logic       query_hit
);

    localparam logic [5:0] GRID_W6 = 6'(GRID_W);
    localparam logic [5:0] GRID_H6 = 6'(GRID_H);

    game_state_e st;
    assign st = game_state_e'(state);

    cell_t       seg_q [MAX_LEN];
    cell_t       seg_d [MAX_LEN];
    logic [4:0]  length_q, length_d;
    dir_e        dir_q, dir_d;
    dir_e        pend_q, pend_d;
    logic        die_q, die_d;
    logic        win_q, win_d;
    logic        eaten_q, eaten_d;

    logic        active;
    logic        tick;
    logic        btn_any;
    dir_e        btn_dir;
    dir_e        turn_dir;
    logic [5:0]  nx6, ny6;
    cell_t       nxt;
    cell_t       apple;
    logic        wall, grow, self_hit;

    function automatic cell_t start_cell(input int i);
        cell_t c;
        c.x = 5'(GRID_W / 2 - i);
        c.y = 5'(GRID_H / 2);
        return c;
    endfunction

    // Once a collision or win is latched, motion stops even before the controller
    // moves the game state on.
    assign active = (st == ST_PLAY) && !die_q && !win_q;

    tick_gen #(.TICK_CYCLES(TICK_CYCLES)) u_tick (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (st == ST_START),
        .en   (active),
        .tick (tick)
    );

    always_comb begin
        btn_any = ~&BTN;
        btn_dir = DIR_RIGHT;
        if      (!BTN[0]) btn_dir = DIR_UP;
        else if (!BTN[1]) btn_dir = DIR_DOWN;
        else if (!BTN[2]) btn_dir = DIR_LEFT;
        else if (!BTN[3]) btn_dir = DIR_RIGHT;
    end

    assign turn_dir = (pend_q == reverse_dir(dir_q)) ? dir_q : pend_q;

    // One extra bit so that stepping off either edge lands outside the grid.
    always_comb begin
        nx6 = {1'b0, seg_q[0].x};
        ny6 = {1'b0, seg_q[0].y};
        case (turn_dir)
            DIR_UP:    ny6 = {1'b0, seg_q[0].y} - 6'd1;
            DIR_DOWN:  ny6 = {1'b0, seg_q[0].y} + 6'd1;
            DIR_LEFT:  nx6 = {1'b0, seg_q[0].x} - 6'd1;
            default:   nx6 = {1'b0, seg_q[0].x} + 6'd1;
        endcase
    end

    assign nxt.x   = nx6[4:0];
    assign nxt.y   = ny6[4:0];
    assign apple.x = apple_x;
    assign apple.y = apple_y;
    assign wall    = (nx6 >= GRID_W6) || (ny6 >= GRID_H6);
    assign grow    = (nxt == apple);

    // The tail cell only counts as body when growing, since it then stays put.
    always_comb begin
        int lim;
        self_hit = 1'b0;
        lim = int'(length_q) - 1 + (grow ? 1 : 0);
        for (int k = 1; k < MAX_LEN; k++) begin
            if ((k < lim) && (seg_q[k] == nxt)) self_hit = 1'b1;
        end
    end

    always_comb begin
        query_hit = 1'b0;
        for (int i = 0; i < MAX_LEN; i++) begin
            if ((i < int'(length_q)) && (seg_q[i].x == query_x) && (seg_q[i].y == query_y))
                query_hit = 1'b1;
        end
    end

    always_comb begin
        for (int i = 0; i < MAX_LEN; i++) seg_d[i] = seg_q[i];
        length_d = length_q;
        dir_d    = dir_q;
        pend_d   = pend_q;
        die_d    = die_q;
        win_d    = win_q;
        eaten_d  = 1'b0;
        if (st == ST_START) begin
            for (int i = 0; i < MAX_LEN; i++) seg_d[i] = start_cell(i);
            length_d = 5'(START_LEN);
            dir_d    = DIR_RIGHT;
            pend_d   = DIR_RIGHT;
            die_d    = 1'b0;
            win_d    = 1'b0;
        end else if (active) begin
            if (btn_any) pend_d = btn_dir;
            if (tick) begin
                dir_d = turn_dir;
                if (wall || self_hit) begin
                    die_d = 1'b1;
                end else begin
                    for (int i = 1; i < MAX_LEN; i++) seg_d[i] = seg_q[i-1];
                    seg_d[0] = nxt;
                    if (grow && (length_q < 5'(MAX_LEN))) begin
                        length_d = length_q + 5'd1;
                        eaten_d  = 1'b1;
                        if (length_q + 5'd1 == 5'(MAX_LEN)) win_d = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MAX_LEN; i++) seg_q[i] <= start_cell(i);
            length_q <= 5'(START_LEN);
            dir_q    <= DIR_RIGHT;
            pend_q   <= DIR_RIGHT;
            die_q    <= 1'b0;
            win_q    <= 1'b0;
            eaten_q  <= 1'b0;
        end else begin
            for (int i = 0; i < MAX_LEN; i++) seg_q[i] <= seg_d[i];
            length_q <= length_d;
            dir_q    <= dir_d;
            pend_q   <= pend_d;
            die_q    <= die_d;
            win_q    <= win_d;
            eaten_q  <= eaten_d;
        end
    end

    assign apple_eaten = eaten_q;
    assign die         = die_q;
    assign win         = win_q;
    assign head_x      = seg_q[0].x;
    assign head_y      = seg_q[0].y;
    assign length      = length_q;

endmodule

// File: tb/tb_snake_motion_engine.sv
// Directed bench for snake_motion_engine: 4-cycle ticks, MAX_LEN=5 so growth to win is short.
module tb_snake_motion_engine;

    localparam int TC = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] state;
    logic [3:0] BTN;
    logic [4:0] apple_x, apple_y;
    logic       apple_eaten, die, win;
    logic [4:0] head_x, head_y, length;
    logic [4:0] query_x, query_y;
    logic       query_hit;

    int errors = 0;
    int checks = 0;

    snake_motion_engine #(
        .GRID_W(32), .GRID_H(24), .MAX_LEN(5), .START_LEN(3), .TICK_CYCLES(TC)
    ) dut (
        .clk(clk), .rst_n(rst_n), .state(state), .BTN(BTN),
        .apple_x(apple_x), .apple_y(apple_y), .apple_eaten(apple_eaten),
        .die(die), .win(win), .head_x(head_x), .head_y(head_y), .length(length),
        .query_x(query_x), .query_y(query_y), .query_hit(query_hit)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic restart();
        state = 2'b10;
        BTN   = 4'hF;
        @(posedge clk); #1;
        state = 2'b01;
    endtask

    task automatic ticks(input int n, input logic [3:0] btn);
        BTN = btn;
        repeat (TC * n) @(posedge clk);
        #1;
    endtask

    task automatic set_apple(input logic [4:0] x, input logic [4:0] y);
        apple_x = x;
        apple_y = y;
    endtask

    initial begin
        rst_n = 1'b0;
        state = 2'b10;
        BTN = 4'hF;
        set_apple(5'd0, 5'd23);
        query_x = 5'd0;
        query_y = 5'd0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_die", die, 0);
        check("rst_win", win, 0);
        check("rst_eaten", apple_eaten, 0);
        check("rst_length", length, 3);
        check("rst_head_x", head_x, 16);
        check("rst_head_y", head_y, 12);
        rst_n = 1'b1;

        // 1: three ticks heading right
        restart();
        ticks(3, 4'hF);
        check("t1_head_x", head_x, 19);
        check("t1_head_y", head_y, 12);
        check("t1_length", length, 3);
        check("t1_die", die, 0);
        query_x = 5'd17; query_y = 5'd12; #1;
        check("t1_query_tail", query_hit, 1);
        query_x = 5'd16; #1;
        check("t1_query_beyond_len", query_hit, 0);

        // 2: reverse is ignored, then turn up
        ticks(1, 4'b1011);
        check("t2_rev_x", head_x, 20);
        check("t2_rev_y", head_y, 12);
        ticks(1, 4'b1110);
        check("t2_up_x", head_x, 20);
        check("t2_up_y", head_y, 11);

        // 3: top-row wall collision, then frozen in Die
        ticks(11, 4'b1110);
        check("t3_top_y", head_y, 0);
        ticks(1, 4'b0111);
        check("t3_row_x", head_x, 21);
        check("t3_row_y", head_y, 0);
        BTN = 4'b1110;
        repeat (TC - 1) @(posedge clk);
        #1;
        check("t3_die_before_tick", die, 0);
        @(posedge clk); #1;
        check("t3_die", die, 1);
        check("t3_win", win, 0);
        check("t3_hold_x", head_x, 21);
        check("t3_hold_y", head_y, 0);
        state = 2'b00;
        ticks(2, 4'hF);
        check("t3_frozen_x", head_x, 21);
        check("t3_frozen_y", head_y, 0);
        check("t3_die_level", die, 1);

        // 4: apple directly ahead of the reset snake
        restart();
        check("t4_start_die", die, 0);
        check("t4_start_len", length, 3);
        check("t4_start_x", head_x, 16);
        set_apple(5'd17, 5'd12);
        ticks(1, 4'hF);
        check("t4_eaten", apple_eaten, 1);
        check("t4_length", length, 4);
        check("t4_head_x", head_x, 17);
        set_apple(5'd0, 5'd23);
        @(posedge clk); #1;
        check("t4_eaten_pulse", apple_eaten, 0);

        // 5: second apple reaches MAX_LEN
        set_apple(5'd18, 5'd12);
        repeat (TC - 1) @(posedge clk);
        #1;
        check("t5_length", length, 5);
        check("t5_win", win, 1);
        check("t5_eaten", apple_eaten, 1);
        check("t5_die", die, 0);
        set_apple(5'd0, 5'd23);
        state = 2'b11;
        ticks(1, 4'hF);
        check("t5_frozen_x", head_x, 18);
        check("t5_win_level", win, 1);
        state = 2'b10;
        @(posedge clk); #1;
        check("t5_start_win", win, 0);
        check("t5_start_len", length, 3);
        check("t5_start_x", head_x, 16);

        // 6a: length-4 loop into the vacating tail cell
        restart();
        set_apple(5'd17, 5'd12);
        ticks(1, 4'hF);
        check("t6a_len", length, 4);
        set_apple(5'd0, 5'd23);
        ticks(1, 4'b0110);
        check("t6a_up_x", head_x, 17);
        check("t6a_up_y", head_y, 11);
        ticks(1, 4'b1011);
        check("t6a_left_x", head_x, 16);
        ticks(1, 4'b1101);
        check("t6a_die", die, 0);
        check("t6a_head_x", head_x, 16);
        check("t6a_head_y", head_y, 12);
        check("t6a_len_after", length, 4);

        // 6b: same loop with the apple on the tail cell
        restart();
        set_apple(5'd17, 5'd12);
        ticks(1, 4'hF);
        set_apple(5'd0, 5'd23);
        ticks(1, 4'b1110);
        ticks(1, 4'b1011);
        set_apple(5'd16, 5'd12);
        ticks(1, 4'b1101);
        check("t6b_die", die, 1);
        check("t6b_win", win, 0);
        check("t6b_head_x", head_x, 16);
        check("t6b_head_y", head_y, 11);
        check("t6b_len", length, 4);
        check("t6b_eaten", apple_eaten, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
